// File: rtl/mastermind_pkg.sv
// mastermind_pkg
//   Shared definitions for the Mastermind scorer core and the VGA display
//   controller: default board geometry, the "no colour" peg value and the
//   scorer FSM state encoding.
package mastermind_pkg;

    localparam int unsigned DEF_NUM_PEGS   = 4;
    localparam int unsigned DEF_COLOR_W    = 3;
    localparam int unsigned DEF_HIST_DEPTH = 8;

    // Colour value 0 marks an empty peg; it never scores.
    localparam logic [DEF_COLOR_W-1:0] COLOR_NONE = '0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXACT   = 2'd1,
        S_PARTIAL = 2'd2,
        S_DONE    = 2'd3
    } score_state_t;

endpackage

// File: rtl/mastermind_scorer.sv
// mastermind_scorer
//   Scores a Mastermind guess against the secret answer, one peg comparison
//   per clock, and keeps the {exact, partial} result of each guess in a small
//   register-array history readable by the display side.
//
// Ports
//   Clk         system clock, rising edge
//   Reset_n     asynchronous active-low reset
//   Start       one-cycle request to score Guess against Answer (IDLE only)
//   Guess       guess pegs, peg i at [i*COLOR_W +: COLOR_W]
//   Answer      secret code, same packing
//   GuessNum    history slot written with this score
//   ClearHist   one-cycle request to zero the history (IDLE, no Start)
//   HistRdAddr  history read address
//   HistRdData  {exact, partial} at HistRdAddr, combinational
//   Busy        scoring in progress (EXACT or PARTIAL)
//   Done        one-cycle pulse when the score is final
//   Exact       right colour, right position
//   Partial     right colour, wrong position
//   Win         Exact == NUM_PEGS
module mastermind_scorer
    import mastermind_pkg::*;
#(
    parameter int unsigned NUM_PEGS   = DEF_NUM_PEGS,
    parameter int unsigned COLOR_W    = DEF_COLOR_W,
    parameter int unsigned HIST_DEPTH = DEF_HIST_DEPTH
) (
    input  logic                                 Clk,
    input  logic                                 Reset_n,
    input  logic                                 Start,
    input  logic [NUM_PEGS*COLOR_W-1:0]          Guess,
    input  logic [NUM_PEGS*COLOR_W-1:0]          Answer,
    input  logic [$clog2(HIST_DEPTH)-1:0]        GuessNum,
    input  logic                                 ClearHist,
    input  logic [$clog2(HIST_DEPTH)-1:0]        HistRdAddr,
    output logic [2*$clog2(NUM_PEGS+1)-1:0]      HistRdData,
    output logic                                 Busy,
    output logic                                 Done,
    output logic [$clog2(NUM_PEGS+1)-1:0]        Exact,
    output logic [$clog2(NUM_PEGS+1)-1:0]        Partial,
    output logic                                 Win
);

    localparam int unsigned CNT_W  = $clog2(NUM_PEGS + 1);
    localparam int unsigned ADDR_W = $clog2(HIST_DEPTH);
    localparam int unsigned PEG_W  = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;
    localparam logic [PEG_W-1:0] LAST_PEG = PEG_W'(NUM_PEGS - 1);

    score_state_t state_q, state_d;

    logic [NUM_PEGS*COLOR_W-1:0] guess_q, answer_q;
    logic [ADDR_W-1:0]           slot_q;
    logic [CNT_W-1:0]            exact_q, partial_q;
    logic [NUM_PEGS-1:0]         used_g_q, used_a_q;
    logic [PEG_W-1:0]            idx_i_q, idx_j_q;
    logic [2*CNT_W-1:0]          hist_q [HIST_DEPTH];

    logic [COLOR_W-1:0] g_peg, a_peg_i, a_peg_j;

    assign g_peg   = guess_q[idx_i_q*COLOR_W +: COLOR_W];
    assign a_peg_i = answer_q[idx_i_q*COLOR_W +: COLOR_W];
    assign a_peg_j = answer_q[idx_j_q*COLOR_W +: COLOR_W];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state_q)
            S_IDLE:    if (Start) state_d = S_EXACT;
            S_EXACT: begin
                Busy = 1'b1;
                if (idx_i_q == LAST_PEG) state_d = S_PARTIAL;
            end
            S_PARTIAL: begin
                Busy = 1'b1;
                if (idx_i_q == LAST_PEG && idx_j_q == LAST_PEG) state_d = S_DONE;
            end
            S_DONE: begin
                Done    = 1'b1;
                state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    // The used flags guarantee each peg is counted at most once, so
    // exact + partial is bounded by NUM_PEGS and the counters cannot wrap.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            guess_q   <= '0;
            answer_q  <= '0;
            slot_q    <= '0;
            exact_q   <= '0;
            partial_q <= '0;
            used_g_q  <= '0;
            used_a_q  <= '0;
            idx_i_q   <= '0;
            idx_j_q   <= '0;
            for (int unsigned k = 0; k < HIST_DEPTH; k++) hist_q[k] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        guess_q   <= Guess;
                        answer_q  <= Answer;
                        slot_q    <= GuessNum;
                        exact_q   <= '0;
                        partial_q <= '0;
                        used_g_q  <= '0;
                        used_a_q  <= '0;
                        idx_i_q   <= '0;
                        idx_j_q   <= '0;
                    end else if (ClearHist) begin
                        for (int unsigned k = 0; k < HIST_DEPTH; k++) hist_q[k] <= '0;
                    end
                end
                S_EXACT: begin
                    if (g_peg == a_peg_i && g_peg != COLOR_NONE) begin
                        exact_q           <= exact_q + CNT_W'(1);
                        used_g_q[idx_i_q] <= 1'b1;
                        used_a_q[idx_i_q] <= 1'b1;
                    end
                    idx_i_q <= (idx_i_q == LAST_PEG) ? '0 : idx_i_q + PEG_W'(1);
                end
                S_PARTIAL: begin
                    if (!used_g_q[idx_i_q] && !used_a_q[idx_j_q] &&
                        g_peg == a_peg_j && g_peg != COLOR_NONE) begin
                        partial_q         <= partial_q + CNT_W'(1);
                        used_g_q[idx_i_q] <= 1'b1;
                        used_a_q[idx_j_q] <= 1'b1;
                    end
                    // i is the outer loop, j the inner loop.
                    if (idx_j_q == LAST_PEG) begin
                        idx_j_q <= '0;
                        idx_i_q <= (idx_i_q == LAST_PEG) ? '0 : idx_i_q + PEG_W'(1);
                    end else begin
                        idx_j_q <= idx_j_q + PEG_W'(1);
                    end
                end
                S_DONE:  hist_q[slot_q] <= {exact_q, partial_q};
                default: ;
            endcase
        end
    end

    assign Exact      = exact_q;
    assign Partial    = partial_q;
    assign Win        = (exact_q == CNT_W'(NUM_PEGS));
    assign HistRdData = hist_q[HistRdAddr];

endmodule

// File: tb/tb_mastermind_scorer.sv
// tb_mastermind_scorer
//   Randomised and directed scoring against a colour-count reference model,
//   with history, latency, ignore-Start, ClearHist and mid-score reset checks.
module tb_mastermind_scorer;

    localparam int N   = 4;
    localparam int CW  = 3;
    localparam int HD  = 8;
    localparam int LAT = 1 + N + N * N;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Start = 1'b0;
    logic [N*CW-1:0] Guess = '0;
    logic [N*CW-1:0] Answer = '0;
    logic [2:0]    GuessNum = '0;
    logic          ClearHist = 1'b0;
    logic [2:0]    HistRdAddr = '0;
    logic [5:0]    HistRdData;
    logic          Busy, Done, Win;
    logic [2:0]    Exact, Partial;

    int n_checks = 0;
    int n_errors = 0;
    int hist_model [HD];

    mastermind_scorer #(.NUM_PEGS(N), .COLOR_W(CW), .HIST_DEPTH(HD)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Guess(Guess),
        .Answer(Answer), .GuessNum(GuessNum), .ClearHist(ClearHist),
        .HistRdAddr(HistRdAddr), .HistRdData(HistRdData), .Busy(Busy),
        .Done(Done), .Exact(Exact), .Partial(Partial), .Win(Win)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*CW-1:0] pack(input int p0, input int p1, input int p2, input int p3);
        logic [N*CW-1:0] v;
        v = '0;
        v[0*CW +: CW] = CW'(p0);
        v[1*CW +: CW] = CW'(p1);
        v[2*CW +: CW] = CW'(p2);
        v[3*CW +: CW] = CW'(p3);
        return v;
    endfunction

    // Exact: equal non-zero pegs in place. Partial: for every non-zero colour,
    // the smaller of its leftover counts in guess and answer.
    function automatic void model(input logic [N*CW-1:0] g, input logic [N*CW-1:0] a,
                                  output int ex, output int pa);
        int cg [8];
        int ca [8];
        int gi, ai;
        ex = 0;
        pa = 0;
        for (int c = 0; c < 8; c++) begin cg[c] = 0; ca[c] = 0; end
        for (int i = 0; i < N; i++) begin
            gi = int'(g[i*CW +: CW]);
            ai = int'(a[i*CW +: CW]);
            if (gi == ai && gi != 0) ex++;
            else begin cg[gi]++; ca[ai]++; end
        end
        for (int c = 1; c < 8; c++) pa += (cg[c] < ca[c]) ? cg[c] : ca[c];
    endfunction

    task automatic sweep_hist(input string tag);
        for (int k = 0; k < HD; k++) begin
            HistRdAddr = 3'(k);
            #1;
            check(tag, int'(HistRdData), hist_model[k]);
        end
    endtask

    // Runs one score from IDLE and watches 30 cycles. extra_at re-asserts
    // Start in that cycle; restart_in_done pulses Start during Done;
    // clr_too raises ClearHist together with Start; scramble changes the
    // inputs right after the Start cycle.
    task automatic run_score(input logic [N*CW-1:0] g, input logic [N*CW-1:0] a,
                             input int slot, input bit scramble, input int extra_at,
                             input bit restart_in_done, input bit clr_too);
        int ex, pa, cyc, dones, done_cyc;
        model(g, a, ex, pa);
        Guess = g; Answer = a; GuessNum = 3'(slot);
        Start = 1'b1; ClearHist = clr_too;
        @(posedge Clk); #1;
        Start = 1'b0; ClearHist = 1'b0;
        cyc = 1; dones = 0; done_cyc = 0;
        check("busy_c1", int'(Busy), 1);
        check("exact_clr", int'(Exact), 0);
        check("partial_clr", int'(Partial), 0);
        if (scramble) begin
            Guess = N*CW'($urandom); Answer = N*CW'($urandom); GuessNum = 3'($urandom);
        end
        while (cyc <= 30) begin
            if (Done) begin
                dones++;
                if (dones == 1) begin
                    done_cyc = cyc;
                    check("exact", int'(Exact), ex);
                    check("partial", int'(Partial), pa);
                    check("win", int'(Win), (ex == N) ? 1 : 0);
                end
            end
            if (done_cyc != 0 && cyc == done_cyc + 3) begin
                check("hold_exact", int'(Exact), ex);
                check("hold_partial", int'(Partial), pa);
                check("idle_busy", int'(Busy), 0);
            end
            Start = (cyc == extra_at) || (restart_in_done && Done);
            @(posedge Clk); #1;
            cyc++;
        end
        Start = 1'b0;
        check("done_count", dones, 1);
        check("latency", done_cyc, LAT);
        hist_model[slot] = ex * 8 + pa;
        HistRdAddr = 3'(slot);
        #1;
        check("hist_slot", int'(HistRdData), hist_model[slot]);
    endtask

    initial begin
        int cyc, dones;
        logic [N*CW-1:0] g, a;
        for (int k = 0; k < HD; k++) hist_model[k] = 0;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        check("rst_busy", int'(Busy), 0);
        check("rst_done", int'(Done), 0);
        check("rst_exact", int'(Exact), 0);
        check("rst_partial", int'(Partial), 0);
        check("rst_win", int'(Win), 0);
        sweep_hist("rst_hist");
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Directed cases
        run_score(pack(1, 1, 1, 1), pack(1, 1, 1, 1), 0, 1'b0, 0, 1'b0, 1'b0);
        run_score(pack(1, 2, 3, 4), pack(4, 3, 2, 1), 2, 1'b0, 0, 1'b0, 1'b0);
        HistRdAddr = 3'd2; #1;
        check("hist_0_4", int'(HistRdData), 6'b000_100);
        run_score(pack(1, 2, 1, 3), pack(1, 1, 2, 2), 3, 1'b1, 0, 1'b0, 1'b0);
        run_score(pack(0, 0, 0, 0), pack(0, 0, 0, 0), 4, 1'b0, 0, 1'b1, 1'b0);
        run_score(pack(5, 6, 7, 5), pack(5, 5, 6, 0), 5, 1'b0, 5, 1'b0, 1'b0);

        // Start and ClearHist together: score proceeds, history kept
        run_score(pack(2, 2, 0, 3), pack(2, 3, 3, 2), 6, 1'b0, 0, 1'b0, 1'b1);
        sweep_hist("clr_dropped");

        // ClearHist alone in IDLE
        ClearHist = 1'b1;
        @(posedge Clk); #1;
        ClearHist = 1'b0;
        for (int k = 0; k < HD; k++) hist_model[k] = 0;
        sweep_hist("clr_hist");

        // Randomised scores; small colour range forces duplicates
        for (int t = 0; t < 24; t++) begin
            int hi;
            hi = (t % 2 == 0) ? 3 : 7;
            g = pack($urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi));
            a = pack($urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi));
            if (t % 5 == 0) g = a;
            run_score(g, a, $urandom_range(0, HD - 1), (t % 3 == 0), 0, 1'b0, 1'b0);
        end
        sweep_hist("rand_hist");

        // Reset in the middle of a score
        Guess = pack(3, 3, 3, 3); Answer = pack(3, 3, 3, 3); GuessNum = 3'd7;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (9) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        for (int k = 0; k < HD; k++) hist_model[k] = 0;
        check("mid_rst_busy", int'(Busy), 0);
        check("mid_rst_done", int'(Done), 0);
        check("mid_rst_exact", int'(Exact), 0);
        check("mid_rst_partial", int'(Partial), 0);
        check("mid_rst_win", int'(Win), 0);
        sweep_hist("mid_rst_hist");
        @(negedge Clk);
        Reset_n = 1'b1;
        dones = 0;
        for (cyc = 0; cyc < 30; cyc++) begin
            @(posedge Clk); #1;
            if (Done) dones++;
        end
        check("no_done_after_rst", dones, 0);
        sweep_hist("post_rst_hist");
        run_score(pack(3, 1, 4, 1), pack(1, 3, 4, 0), 7, 1'b0, 0, 1'b0, 1'b0);
        sweep_hist("final_hist");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1);
    end

endmodule
